// File: rtl/activation_share_ctrl.sv
// activation_share_ctrl
// Shares one fixed-latency, stall-free activation unit between NUM_REQ requesters.
// A round-robin arbiter issues at most one word per cycle. A tag pipeline follows each
// word through the unit and returns its result to the return FIFO of the requester that
// issued it. Per-requester credits hold back an issue unless a FIFO slot is guaranteed,
// so a result is never dropped.
module activation_share_ctrl #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_IN_WIDTH  = 16,
  parameter int DATA_OUT_WIDTH = 19,
  parameter int LATENCY        = 4,
  parameter int OUT_DEPTH      = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0][DATA_IN_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ-1:0]                       req_valid,
  output logic [NUM_REQ-1:0]                       req_ready,
  output logic [NUM_REQ-1:0][DATA_OUT_WIDTH-1:0]   resp_data,
  output logic [NUM_REQ-1:0]                       resp_valid,
  input  logic [NUM_REQ-1:0]                       resp_ready,
  output logic [DATA_IN_WIDTH-1:0]                 unit_data_in,
  output logic                                     unit_data_in_valid,
  output logic                                     unit_data_out_ready,
  input  logic [DATA_OUT_WIDTH-1:0]                unit_data_out,
  input  logic                                     unit_data_out_valid,
  output logic [$clog2(LATENCY+1)-1:0]             inflight,
  output logic                                     err_orphan
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int ADR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int INF_W = $clog2(LATENCY + 1);

  // Arbitration state and tag pipeline
  logic [PTR_W-1:0]          r_ptr;
  logic [LATENCY-1:0]        r_tag_vld;
  logic [PTR_W-1:0]          r_tag_idx [LATENCY];

  // Per-requester return FIFOs
  logic [DATA_OUT_WIDTH-1:0] r_mem [NUM_REQ][OUT_DEPTH];
  logic [ADR_W-1:0]          r_rd  [NUM_REQ];
  logic [ADR_W-1:0]          r_wr  [NUM_REQ];
  logic [CNT_W-1:0]          r_cnt [NUM_REQ];
  logic                      r_err;

  // Combinational nets
  logic [INF_W-1:0]          w_inf_i [NUM_REQ];
  logic [NUM_REQ-1:0]        w_elig;
  logic                      w_gnt_vld;
  logic [PTR_W-1:0]          w_gnt_idx;
  logic                      w_ret_vld;
  logic [PTR_W-1:0]          w_ret_idx;
  logic [NUM_REQ-1:0]        w_push;
  logic [NUM_REQ-1:0]        w_pop;
  logic [INF_W-1:0]          w_inf;

  function automatic logic [ADR_W-1:0] adr_inc(input logic [ADR_W-1:0] a);
    return (a == ADR_W'(OUT_DEPTH - 1)) ? '0 : a + ADR_W'(1);
  endfunction

  // Credit check. A tag still counts in its last stage, even when it retires this
  // cycle, so the accounting stays conservative. Nothing is eligible while in reset.
  always_comb begin
    w_inf_i = '{default: '0};
    w_elig  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int s = 0; s < LATENCY; s++) begin
        if (r_tag_vld[s] && (r_tag_idx[s] == PTR_W'(i)))
          w_inf_i[i] = w_inf_i[i] + INF_W'(1);
      end
      w_elig[i] = rst && req_valid[i] &&
                  ((int'(r_cnt[i]) + int'(w_inf_i[i])) < OUT_DEPTH);
    end
  end

  // Round-robin pick: first eligible index at or above the pointer, with wrap.
  always_comb begin : p_arb
    int c;
    c         = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(r_ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!w_gnt_vld && w_elig[c]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = PTR_W'(c);
      end
    end
  end

  // Steer the granted word to the unit and acknowledge only the granted requester.
  always_comb begin
    req_ready    = '0;
    unit_data_in = '0;
    if (w_gnt_vld) begin
      req_ready[w_gnt_idx] = 1'b1;
      unit_data_in         = req_data[w_gnt_idx];
    end
  end

  assign unit_data_in_valid  = w_gnt_vld;
  assign unit_data_out_ready = rst;

  // Move the priority pointer past the last winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_gnt_vld) begin
      r_ptr <= (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
    end
  end

  // The tag pipeline shifts every cycle. Its last stage lines up with the unit output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag_vld <= '0;
      for (int s = 0; s < LATENCY; s++) r_tag_idx[s] <= '0;
    end else begin
      r_tag_vld[0] <= w_gnt_vld;
      r_tag_idx[0] <= w_gnt_idx;
      for (int s = 1; s < LATENCY; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_idx[s] <= r_tag_idx[s-1];
      end
    end
  end

  assign w_ret_vld = unit_data_out_valid && r_tag_vld[LATENCY-1];
  assign w_ret_idx = r_tag_idx[LATENCY-1];

  // Count of tagged items still inside the unit.
  always_comb begin
    w_inf = '0;
    for (int s = 0; s < LATENCY; s++) begin
      if (r_tag_vld[s]) w_inf = w_inf + INF_W'(1);
    end
  end

  assign inflight = w_inf;

  // Decode FIFO push (tagged return) and pop (requester takes a non-empty head).
  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_push[i] = w_ret_vld && (w_ret_idx == PTR_W'(i));
      w_pop[i]  = resp_ready[i] && (r_cnt[i] != '0);
    end
  end

  // Return FIFO storage and pointers. A push and a pop in one cycle leave the count as is.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_rd[i]  <= '0;
        r_wr[i]  <= '0;
        r_cnt[i] <= '0;
        for (int d = 0; d < OUT_DEPTH; d++) r_mem[i][d] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_push[i]) begin
          r_mem[i][r_wr[i]] <= unit_data_out;
          r_wr[i]           <= adr_inc(r_wr[i]);
        end
        if (w_pop[i]) r_rd[i] <= adr_inc(r_rd[i]);
        if (w_push[i] && !w_pop[i])
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (!w_push[i] && w_pop[i])
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

  // Present each FIFO head straight from registered storage.
  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = (r_cnt[i] != '0);
      resp_data[i]  = r_mem[i][r_rd[i]];
    end
  end

  // A result with no live tag is dropped and recorded until the next reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (unit_data_out_valid && !r_tag_vld[LATENCY-1]) begin
      r_err <= 1'b1;
    end
  end

  assign err_orphan = r_err;

`ifndef SYNTHESIS
  // Credits make overflow impossible. Trap it in simulation if that assumption breaks.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        assert (!(w_push[i] && !w_pop[i] && (r_cnt[i] == CNT_W'(OUT_DEPTH))))
          else $error("return FIFO %0d overflow", i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_activation_share_ctrl.sv
// Directed bench for activation_share_ctrl. It uses a behavioural 4-cycle unit that
// computes out = in + 13.
module tb_activation_share_ctrl;

  localparam int NR  = 4;
  localparam int DIW = 16;
  localparam int DOW = 19;
  localparam int LAT = 4;
  localparam int DEP = 2;
  localparam int INW = $clog2(LAT + 1);

  // Hand-derived grant order for the backpressure scenario (requester 1 never pops,
  // except for one cycle at index 18).
  localparam int BP_SEQ [30] = '{0,1,2,3,0,1,2,3,0,
                                 2,3,0,2,3,0,2,3,0,
                                 2,
                                 3,0,1,2,3,0,2,3,0,2,3};

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NR-1:0][DIW-1:0]    req_data;
  logic [NR-1:0]             req_valid;
  logic [NR-1:0]             req_ready;
  logic [NR-1:0][DOW-1:0]    resp_data;
  logic [NR-1:0]             resp_valid;
  logic [NR-1:0]             resp_ready;
  logic [DIW-1:0]            unit_data_in;
  logic                      unit_data_in_valid;
  logic                      unit_data_out_ready;
  logic [DOW-1:0]            unit_data_out;
  logic                      unit_data_out_valid;
  logic [INW-1:0]            inflight;
  logic                      err_orphan;

  logic [LAT-1:0]            m_vld;
  logic [DOW-1:0]            m_dat [LAT];
  logic                      inj;
  logic                      drop;
  logic [DOW-1:0]            inj_data;

  logic [DOW-1:0]            q [NR][$];

  int n_cmp = 0;
  int n_bad = 0;

  activation_share_ctrl #(
    .NUM_REQ(NR), .DATA_IN_WIDTH(DIW), .DATA_OUT_WIDTH(DOW), .LATENCY(LAT), .OUT_DEPTH(DEP)
  ) dut (
    .clk(clk), .rst(rst),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .unit_data_in(unit_data_in), .unit_data_in_valid(unit_data_in_valid),
    .unit_data_out_ready(unit_data_out_ready),
    .unit_data_out(unit_data_out), .unit_data_out_valid(unit_data_out_valid),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  function automatic logic [DOW-1:0] act(input logic [DIW-1:0] x);
    return {3'b000, x} + 19'h0000D;
  endfunction

  // Behavioural activation unit: fixed latency, reset together with the DUT
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_vld <= '0;
      for (int s = 0; s < LAT; s++) m_dat[s] <= '0;
    end else begin
      m_vld    <= {m_vld[LAT-2:0], unit_data_in_valid};
      m_dat[0] <= act(unit_data_in);
      for (int s = 1; s < LAT; s++) m_dat[s] <= m_dat[s-1];
    end
  end

  assign unit_data_out_valid = (m_vld[LAT-1] & ~drop) | inj;
  assign unit_data_out       = inj ? inj_data : m_dat[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid  = '0;
    req_data   = '0;
    resp_ready = '1;
    inj        = 1'b0;
    drop       = 1'b0;
    inj_data   = '0;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0;
    idle_inputs();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    req_valid = '1;
    req_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    tick(); tick(); smp();
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %b want %b", req_ready, 4'b0000); end
    n_cmp++; if (unit_data_in_valid !== 1'b0) begin n_bad++; $display("FAIL reset_in_valid: got %b want 0", unit_data_in_valid); end
    n_cmp++; if (unit_data_out_ready !== 1'b0) begin n_bad++; $display("FAIL reset_out_ready: got %b want 0", unit_data_out_ready); end
    n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
    n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_resp_valid: got %b want %b", resp_valid, 4'b0000); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_orphan); end
    req_valid = '0;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (unit_data_out_ready !== 1'b1) begin n_bad++; $display("FAIL release_out_ready: got %b want 1", unit_data_out_ready); end
  endtask

  task automatic test_single();
    logic [INW-1:0] exp_inf;
    do_reset();
    resp_ready   = '0;
    req_valid    = 4'b0001;
    req_data[0]  = 16'h0100;
    smp();
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_req_ready: got %b want %b", req_ready, 4'b0001); end
    n_cmp++; if (unit_data_in_valid !== 1'b1) begin n_bad++; $display("FAIL single_in_valid: got %b want 1", unit_data_in_valid); end
    n_cmp++; if (unit_data_in !== 16'h0100) begin n_bad++; $display("FAIL single_in_data: got %h want %h", unit_data_in, 16'h0100); end
    n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL single_inflight_t0: got %0d want 0", inflight); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) req_valid = '0;
      smp();
      exp_inf = (k <= 4) ? 3'd1 : 3'd0;
      n_cmp++; if (inflight !== exp_inf) begin n_bad++; $display("FAIL single_inflight_t%0d: got %0d want %0d", k, inflight, exp_inf); end
      if (k < 5) begin
        n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL single_early_resp_t%0d: got %b want %b", k, resp_valid, 4'b0000); end
      end else begin
        n_cmp++; if (resp_valid !== 4'b0001) begin n_bad++; $display("FAIL single_resp_valid_t5: got %b want %b", resp_valid, 4'b0001); end
        n_cmp++; if (resp_data[0] !== 19'h0010D) begin n_bad++; $display("FAIL single_resp_data_t5: got %h want %h", resp_data[0], 19'h0010D); end
      end
    end
    tick();
    resp_ready = 4'b0001;
    smp();
    n_cmp++; if (resp_valid[0] !== 1'b1) begin n_bad++; $display("FAIL single_hold_t6: got %b want 1", resp_valid[0]); end
    tick();
    resp_ready = '0;
    smp();
    n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL single_popped: got %b want %b", resp_valid, 4'b0000); end
  endtask

  task automatic check_returns(input string tag);
    for (int i = 0; i < NR; i++) begin
      if (resp_valid[i] === 1'b1) begin
        n_cmp++;
        if (q[i].size() == 0) begin
          n_bad++; $display("FAIL %s_unexpected_resp%0d: got %h want none", tag, i, resp_data[i]);
        end else begin
          if (resp_data[i] !== q[i][0]) begin n_bad++; $display("FAIL %s_resp_data%0d: got %h want %h", tag, i, resp_data[i], q[i][0]); end
          void'(q[i].pop_front());
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int             g;
    logic [NR-1:0]  exp_rdy;
    logic [DIW-1:0] exp_din;
    do_reset();
    for (int i = 0; i < NR; i++) q[i].delete();
    resp_ready = '1;
    req_valid  = '1;
    for (int n = 0; n < 16; n++) begin
      if (n > 0) tick();
      for (int i = 0; i < NR; i++) req_data[i] = 16'(32'h1000 * i + n);
      smp();
      g       = n % NR;
      exp_rdy = 4'(1 << g);
      exp_din = 16'(32'h1000 * g + n);
      n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_grant_c%0d: got %b want %b", n, req_ready, exp_rdy); end
      n_cmp++; if (unit_data_in !== exp_din) begin n_bad++; $display("FAIL rr_unit_in_c%0d: got %h want %h", n, unit_data_in, exp_din); end
      q[g].push_back(act(exp_din));
      check_returns("rr");
    end
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k == 0) req_valid = '0;
      smp();
      check_returns("rr_drain");
    end
    for (int i = 0; i < NR; i++) begin
      n_cmp++; if (q[i].size() != 0) begin n_bad++; $display("FAIL rr_missing%0d: got %0d outstanding want 0", i, q[i].size()); end
    end
  endtask

  task automatic test_backpressure();
    logic [NR-1:0] exp_rdy;
    int            n1;
    n1 = 0;
    do_reset();
    req_valid = '1;
    for (int n = 0; n < 30; n++) begin
      if (n > 0) tick();
      resp_ready = (n == 18) ? 4'b1111 : 4'b1101;
      for (int i = 0; i < NR; i++) req_data[i] = 16'(32'h2000 + 32'h100 * i + n);
      smp();
      exp_rdy = 4'(1 << BP_SEQ[n]);
      n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL bp_grant_c%0d: got %b want %b", n, req_ready, exp_rdy); end
      if (req_ready[1] === 1'b1) n1++;
      if (n == 12) begin
        n_cmp++; if (resp_valid[1] !== 1'b1) begin n_bad++; $display("FAIL bp_full_valid: got %b want 1", resp_valid[1]); end
        n_cmp++; if (resp_data[1] !== act(16'h2101)) begin n_bad++; $display("FAIL bp_head_first: got %h want %h", resp_data[1], act(16'h2101)); end
      end
      if (n == 19) begin
        n_cmp++; if (resp_data[1] !== act(16'h2105)) begin n_bad++; $display("FAIL bp_head_second: got %h want %h", resp_data[1], act(16'h2105)); end
      end
    end
    n_cmp++; if (n1 != 3) begin n_bad++; $display("FAIL bp_grants_req1: got %0d want 3", n1); end
  endtask

  task automatic test_push_pop();
    do_reset();
    resp_ready  = '0;
    req_valid   = 4'b0100;
    req_data[2] = 16'h0A0A;
    smp();
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL pp_grant_t0: got %b want %b", req_ready, 4'b0100); end
    tick();
    req_data[2] = 16'h0B0B;
    smp();
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL pp_grant_t1: got %b want %b", req_ready, 4'b0100); end
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    resp_ready = 4'b0100;
    smp();
    n_cmp++; if (resp_valid[2] !== 1'b1) begin n_bad++; $display("FAIL pp_valid_t5: got %b want 1", resp_valid[2]); end
    n_cmp++; if (resp_data[2] !== act(16'h0A0A)) begin n_bad++; $display("FAIL pp_head_t5: got %h want %h", resp_data[2], act(16'h0A0A)); end
    tick();
    resp_ready  = '0;
    req_valid   = 4'b0100;
    req_data[2] = 16'h0C0C;
    smp();
    n_cmp++; if (resp_valid[2] !== 1'b1) begin n_bad++; $display("FAIL pp_valid_t6: got %b want 1", resp_valid[2]); end
    n_cmp++; if (resp_data[2] !== act(16'h0B0B)) begin n_bad++; $display("FAIL pp_head_t6: got %h want %h", resp_data[2], act(16'h0B0B)); end
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL pp_credit_one: got %b want %b", req_ready, 4'b0100); end
    tick();
    req_data[2] = 16'h0D0D;
    smp();
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL pp_credit_zero: got %b want %b", req_ready, 4'b0000); end
    tick();
    req_valid  = '0;
    resp_ready = 4'b0100;
    smp();
    n_cmp++; if (resp_data[2] !== act(16'h0B0B)) begin n_bad++; $display("FAIL pp_head_t8: got %h want %h", resp_data[2], act(16'h0B0B)); end
    tick();
    resp_ready = '0;
    smp();
    n_cmp++; if (resp_valid[2] !== 1'b0) begin n_bad++; $display("FAIL pp_empty_t9: got %b want 0", resp_valid[2]); end
    tick(); tick();
    smp();
    n_cmp++; if (resp_valid[2] !== 1'b1) begin n_bad++; $display("FAIL pp_valid_t11: got %b want 1", resp_valid[2]); end
    n_cmp++; if (resp_data[2] !== act(16'h0C0C)) begin n_bad++; $display("FAIL pp_head_t11: got %h want %h", resp_data[2], act(16'h0C0C)); end
  endtask

  task automatic test_orphan();
    do_reset();
    resp_ready = '0;
    inj        = 1'b1;
    inj_data   = 19'h12345;
    smp();
    n_cmp++; if (err_orphan !== 1'b0) begin n_bad++; $display("FAIL orphan_before: got %b want 0", err_orphan); end
    tick();
    inj = 1'b0;
    smp();
    n_cmp++; if (err_orphan !== 1'b1) begin n_bad++; $display("FAIL orphan_set: got %b want 1", err_orphan); end
    n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL orphan_no_push: got %b want %b", resp_valid, 4'b0000); end
    tick(); tick();
    req_valid   = 4'b0001;
    req_data[0] = 16'h0001;
    smp();
    n_cmp++; if (err_orphan !== 1'b1) begin n_bad++; $display("FAIL orphan_sticky: got %b want 1", err_orphan); end
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    drop = 1'b1;
    smp();
    n_cmp++; if (inflight !== 3'd1) begin n_bad++; $display("FAIL retire_inflight_before: got %0d want 1", inflight); end
    tick();
    drop = 1'b0;
    smp();
    n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL retire_inflight_after: got %0d want 0", inflight); end
    n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL retire_no_push: got %b want %b", resp_valid, 4'b0000); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    resp_ready  = '0;
    req_valid   = 4'b0001;
    req_data[0] = 16'h0055;
    smp();
    n_cmp++; if (err_orphan !== 1'b0) begin n_bad++; $display("FAIL mid_err_cleared: got %b want 0", err_orphan); end
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_grant_t0: got %b want %b", req_ready, 4'b0001); end
    tick();
    req_valid = '0;
    tick(); tick();
    req_valid = 4'b0110;
    req_data  = {16'h0000, 16'h0033, 16'h0022, 16'h0000};
    smp();
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL mid_grant_t3: got %b want %b", req_ready, 4'b0010); end
    tick();
    smp();
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL mid_grant_t4: got %b want %b", req_ready, 4'b0100); end
    tick();
    req_valid = 4'b0010;
    smp();
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL mid_grant_t5: got %b want %b", req_ready, 4'b0010); end
    tick();
    req_valid = '0;
    smp();
    n_cmp++; if (inflight !== 3'd3) begin n_bad++; $display("FAIL mid_inflight_pre: got %0d want 3", inflight); end
    n_cmp++; if (resp_valid !== 4'b0001) begin n_bad++; $display("FAIL mid_resp_pre: got %b want %b", resp_valid, 4'b0001); end
    #1 rst = 1'b0;
    req_valid = 4'b1010;
    req_data  = {16'h0077, 16'h0000, 16'h0066, 16'h0000};
    #1;
    n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL mid_resp_in_reset: got %b want %b", resp_valid, 4'b0000); end
    n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL mid_inflight_in_reset: got %0d want 0", inflight); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_ready_in_reset: got %b want %b", req_ready, 4'b0000); end
    smp();
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL mid_first_grant: got %b want %b", req_ready, 4'b0010); end
    n_cmp++; if (unit_data_in !== 16'h0066) begin n_bad++; $display("FAIL mid_first_data: got %h want %h", unit_data_in, 16'h0066); end
    tick();
    req_valid = '0;
    tick(); tick(); tick(); tick();
    smp();
    n_cmp++; if (resp_valid !== 4'b0010) begin n_bad++; $display("FAIL mid_resp_after: got %b want %b", resp_valid, 4'b0010); end
    n_cmp++; if (resp_data[1] !== act(16'h0066)) begin n_bad++; $display("FAIL mid_resp_data_after: got %h want %h", resp_data[1], act(16'h0066)); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_bad++; $display("FAIL mid_no_orphan: got %b want 0", err_orphan); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_push_pop();
    test_orphan();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
